// File: rtl/pipereg_mw_gen_if.sv
// ---------------------------------------------------------------------------
// pipereg_mw_gen_if
// Groups the memory->writeback pipeline register signals into one bundle.
//
// Optional feature macro: PIPEREG_STALL_STATS_EN (adds StallCntW).
//
// Signals
//   ResultM, ReadDataM [DATA_W] : memory-stage ALU result / load data
//   RdM [RD_W]                  : memory-stage destination register index
//   ValidM                      : memory-stage slot holds a real instruction
//   StallW                      : hold writeback stage contents
//   FlushW                      : squash the instruction entering writeback
//   ResultW, ReadDataW [DATA_W] : registered copies
//   RdW [RD_W]                  : registered destination index
//   ValidW                      : writeback slot valid
//   ReadyW                      : stage is running (bubble phase finished)
//   StallCntW [16]              : saturating stall-edge count (macro only)
//
// Modports
//   master : upstream pipeline / control side, drives the M-side inputs
//   slave  : the pipeline register itself
// ---------------------------------------------------------------------------
interface pipereg_mw_gen_if #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
);
    logic [DATA_W-1:0] ResultM;
    logic [DATA_W-1:0] ReadDataM;
    logic [RD_W-1:0]   RdM;
    logic              ValidM;
    logic              StallW;
    logic              FlushW;

    logic [DATA_W-1:0] ResultW;
    logic [DATA_W-1:0] ReadDataW;
    logic [RD_W-1:0]   RdW;
    logic              ValidW;
    logic              ReadyW;
`ifdef PIPEREG_STALL_STATS_EN
    logic [15:0]       StallCntW;

    modport master (
        output ResultM, ReadDataM, RdM, ValidM, StallW, FlushW,
        input  ResultW, ReadDataW, RdW, ValidW, ReadyW, StallCntW
    );

    modport slave (
        input  ResultM, ReadDataM, RdM, ValidM, StallW, FlushW,
        output ResultW, ReadDataW, RdW, ValidW, ReadyW, StallCntW
    );
`else
    modport master (
        output ResultM, ReadDataM, RdM, ValidM, StallW, FlushW,
        input  ResultW, ReadDataW, RdW, ValidW, ReadyW
    );

    modport slave (
        input  ResultM, ReadDataM, RdM, ValidM, StallW, FlushW,
        output ResultW, ReadDataW, RdW, ValidW, ReadyW
    );
`endif
endinterface

// File: rtl/pipereg_mw_gen.sv
// ---------------------------------------------------------------------------
// pipereg_mw_gen
// Memory -> writeback pipeline register with a start-up bubble phase.
//
// After reset release the stage ignores INIT_BUBBLES falling clock edges
// (outputs held at zero, ReadyW low), then runs: on every falling edge it
// either flushes (FlushW), holds (StallW) or loads the memory-stage values.
// FlushW has priority over StallW, which has priority over a load.
//
// Optional feature macro: PIPEREG_STALL_STATS_EN
//   When defined, a 16-bit saturating counter StallCntW counts RUN edges on
//   which the stage held because of StallW (flush edges are not counted).
//
// Parameters
//   DATA_W       : width of result / load data (default 32)
//   RD_W         : width of destination register index (default 5)
//   INIT_BUBBLES : falling edges ignored after reset release, 0..15
//
// Ports
//   clk   : clock, all state changes on its falling edge
//   reset : asynchronous, active-high reset
//   bus   : pipereg_mw_gen_if.slave bundle (see interface header)
// ---------------------------------------------------------------------------
module pipereg_mw_gen #(
    parameter int DATA_W       = 32,
    parameter int RD_W         = 5,
    parameter int INIT_BUBBLES = 1
) (
    input  logic                clk,
    input  logic                reset,
    pipereg_mw_gen_if.slave     bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // With zero bubbles the stage comes out of reset already running.
    localparam state_t     RST_STATE = (INIT_BUBBLES == 0) ? ST_RUN : ST_INIT;
    localparam logic [3:0] RST_CNT   = 4'(INIT_BUBBLES);
    localparam logic       RST_READY = (INIT_BUBBLES == 0);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic              ready_q, ready_d;

    logic [DATA_W-1:0] result_q,   result_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic [RD_W-1:0]   rd_q,       rd_d;
    logic              valid_q,    valid_d;

`ifdef PIPEREG_STALL_STATS_EN
    logic [15:0]       stall_cnt_q, stall_cnt_d;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end
        return v + 16'd1;
    endfunction
`endif

    // ------------------------------------------------------------------
    // Next-state / datapath selection
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        readdata_d = readdata_q;
        rd_d       = rd_q;
        valid_d    = valid_q;
`ifdef PIPEREG_STALL_STATS_EN
        stall_cnt_d = stall_cnt_q;
`endif

        unique case (state_q)
            ST_INIT: begin
                // The edge that sees the counter at 1 is the last bubble:
                // the stage becomes ready on it but does not load on it.
                // A zero counter cannot occur here, but is treated the
                // same way so the FSM can never stay stuck in INIT.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            ST_RUN: begin
                if (bus.FlushW) begin
                    result_d   = '0;
                    readdata_d = '0;
                    rd_d       = '0;
                    valid_d    = 1'b0;
                end else if (bus.StallW) begin
                    // Contents hold; only the statistics advance.
`ifdef PIPEREG_STALL_STATS_EN
                    stall_cnt_d = sat_inc16(stall_cnt_q);
`endif
                end else begin
                    result_d   = bus.ResultM;
                    readdata_d = bus.ReadDataM;
                    rd_d       = bus.RdM;
                    valid_d    = bus.ValidM;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase

        ready_d = (state_d == ST_RUN);
    end

    // ------------------------------------------------------------------
    // Registers (falling edge, asynchronous reset)
    // ------------------------------------------------------------------
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RST_STATE;
            cnt_q      <= RST_CNT;
            ready_q    <= RST_READY;
            result_q   <= '0;
            readdata_q <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            result_q   <= result_d;
            readdata_q <= readdata_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
        end
    end

`ifdef PIPEREG_STALL_STATS_EN
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.StallCntW = stall_cnt_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.ResultW   = result_q;
    assign bus.ReadDataW = readdata_q;
    assign bus.RdW       = rd_q;
    assign bus.ValidW    = valid_q;
    assign bus.ReadyW    = ready_q;

endmodule

// File: tb/tb_pipereg_mw_gen.sv
// ---------------------------------------------------------------------------
// tb_pipereg_mw_gen
// Drives three instances (INIT_BUBBLES = 0, 1, 3) with the same stimulus and
// compares each against a bubble-counting reference model after every
// falling edge and inside asynchronous reset pulses.
// ---------------------------------------------------------------------------
module tb_pipereg_mw_gen;
    localparam int DATA_W = 32;
    localparam int RD_W   = 5;
    localparam int NINST  = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    pipereg_mw_gen_if #(.DATA_W(DATA_W), .RD_W(RD_W)) if0 ();
    pipereg_mw_gen_if #(.DATA_W(DATA_W), .RD_W(RD_W)) if1 ();
    pipereg_mw_gen_if #(.DATA_W(DATA_W), .RD_W(RD_W)) if3 ();

    pipereg_mw_gen #(.DATA_W(DATA_W), .RD_W(RD_W), .INIT_BUBBLES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(if0)
    );
    pipereg_mw_gen #(.DATA_W(DATA_W), .RD_W(RD_W), .INIT_BUBBLES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(if1)
    );
    pipereg_mw_gen #(.DATA_W(DATA_W), .RD_W(RD_W), .INIT_BUBBLES(3)) dut3 (
        .clk(clk), .reset(reset), .bus(if3)
    );

    int n_tests;
    int n_fail;

    // Current stimulus
    logic [31:0] cur_res, cur_rdd;
    logic [4:0]  cur_rd;
    logic        cur_v, cur_s, cur_f;

    // Reference model, one slot per instance
    int          nb  [NINST] = '{0, 1, 3};
    int          bl  [NINST];           // bubbles still to ignore
    logic        mrdy[NINST];
    logic [31:0] mres[NINST];
    logic [31:0] mrdd[NINST];
    logic [4:0]  mrd [NINST];
    logic        mv  [NINST];
    int          msc [NINST];

    task automatic model_reset();
        for (int k = 0; k < NINST; k++) begin
            bl[k]   = nb[k];
            mrdy[k] = (nb[k] == 0);
            mres[k] = '0;
            mrdd[k] = '0;
            mrd[k]  = '0;
            mv[k]   = 1'b0;
            msc[k]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < NINST; k++) begin
            if (bl[k] > 0) begin
                bl[k] = bl[k] - 1;
                if (bl[k] == 0) mrdy[k] = 1'b1;
            end else if (cur_f) begin
                mres[k] = '0;
                mrdd[k] = '0;
                mrd[k]  = '0;
                mv[k]   = 1'b0;
            end else if (cur_s) begin
                msc[k] = (msc[k] < 65535) ? msc[k] + 1 : 65535;
            end else begin
                mres[k] = cur_res;
                mrdd[k] = cur_rdd;
                mrd[k]  = cur_rd;
                mv[k]   = cur_v;
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s inst%0d observed=%0h expected=%0h t=%0t", tag, k, obs, exp, $time);
        end
    endtask

    task automatic chk_inst(input int k, input logic [31:0] res, input logic [31:0] rdd,
                            input logic [4:0] rd, input logic v, input logic rdy);
        chk("ResultW",   k, 64'(res), 64'(mres[k]));
        chk("ReadDataW", k, 64'(rdd), 64'(mrdd[k]));
        chk("RdW",       k, 64'(rd),  64'(mrd[k]));
        chk("ValidW",    k, 64'(v),   64'(mv[k]));
        chk("ReadyW",    k, 64'(rdy), 64'(mrdy[k]));
    endtask

    task automatic check_all();
        chk_inst(0, if0.ResultW, if0.ReadDataW, if0.RdW, if0.ValidW, if0.ReadyW);
        chk_inst(1, if1.ResultW, if1.ReadDataW, if1.RdW, if1.ValidW, if1.ReadyW);
        chk_inst(2, if3.ResultW, if3.ReadDataW, if3.RdW, if3.ValidW, if3.ReadyW);
`ifdef PIPEREG_STALL_STATS_EN
        chk("StallCntW", 0, 64'(if0.StallCntW), 64'(msc[0]));
        chk("StallCntW", 1, 64'(if1.StallCntW), 64'(msc[1]));
        chk("StallCntW", 2, 64'(if3.StallCntW), 64'(msc[2]));
`endif
    endtask

    task automatic drive(input logic [31:0] r, input logic [31:0] d, input logic [4:0] rd,
                         input logic v, input logic s, input logic f);
        cur_res = r; cur_rdd = d; cur_rd = rd; cur_v = v; cur_s = s; cur_f = f;
        if0.ResultM = r; if0.ReadDataM = d; if0.RdM = rd; if0.ValidM = v; if0.StallW = s; if0.FlushW = f;
        if1.ResultM = r; if1.ReadDataM = d; if1.RdM = rd; if1.ValidM = v; if1.StallW = s; if1.FlushW = f;
        if3.ResultM = r; if3.ReadDataM = d; if3.RdM = rd; if3.ValidM = v; if3.StallW = s; if3.FlushW = f;
    endtask

    // Entered just after a rising edge; inputs change there, the DUT acts on
    // the following falling edge, and outputs are sampled 1 time unit later.
    task automatic step(input logic [31:0] r, input logic [31:0] d, input logic [4:0] rd,
                        input logic v, input logic s, input logic f, input bit do_chk);
        drive(r, d, rd, v, s, f);
        @(negedge clk);
        model_edge();
        #1;
        if (do_chk) check_all();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse entirely between two falling edges.
    task automatic reset_pulse();
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive('0, '0, '0, 1'b0, 1'b0, 1'b0);

        // Reset state
        #1 reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_all();
        @(posedge clk); #1;
        check_all();
        reset = 1'b0;

        // First bubble edge then first load (INIT_BUBBLES=1); third edge
        // raises ReadyW and fourth edge loads for INIT_BUBBLES=3.
        step(32'hA5A5_0001, 32'h0000_1111, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step(32'hA5A5_0001, 32'h0000_1111, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
        step(32'hA5A5_0002, 32'h0000_2222, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        step(32'hA5A5_0003, 32'h0000_3333, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);

        // Load Rd=7, then stall four edges while RdM=9
        step(32'h0000_0007, 32'h7777_7777, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (4) step(32'h0000_0009, 32'h9999_9999, 5'd9, 1'b1, 1'b1, 1'b0, 1'b1);

        // Stall and flush together: flush wins, no stall counted
        step(32'hDEAD_BEEF, 32'hCAFE_F00D, 5'd12, 1'b1, 1'b1, 1'b1, 1'b1);

        // Valid instruction with Rd=0 loads unchanged
        step(32'h1234_5678, 32'h8765_4321, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset pulse between edges while ValidW=1, then INIT re-entered
        reset_pulse();
        repeat (4) step(32'h0BAD_0000, 32'h0000_0BAD, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1);
        repeat (2) step($urandom, $urandom, 5'($urandom), 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of INIT
        reset_pulse();
        step(32'h1111_0000, 32'h2222_0000, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        reset_pulse();
        repeat (4) step(32'h3333_0000, 32'h4444_0000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b1);

        // Reset during a stall
        step(32'h5555_0000, 32'h6666_0000, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
        reset_pulse();
        repeat (4) step(32'h7777_0000, 32'h8888_0000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);

        // Randomized traffic with occasional reset pulses
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 59) == 0) reset_pulse();
            step($urandom, $urandom, 5'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 1'b1);
        end

`ifdef PIPEREG_STALL_STATS_EN
        // Stall counter saturation
        reset_pulse();
        repeat (3) step('0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (65534) step('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_all();
        repeat (3) step('0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
